// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline control partner of the decode/execute register in the 5-stage
//   RV32I core. Resolves data hazards (forwarding and load-use stalls),
//   control hazards (taken branch flushes) and structural hazards from a
//   multi-cycle multiply/divide unit. It also keeps a watchdog on that unit
//   and a saturating count of fetch-stall cycles.
//
// Parameters
//   MAX_BUSY  maximum BUSY cycles before the watchdog aborts the op (>= 2)
//   CNT_W     width of the stall-cycle performance counter
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   rs1D, rs2D              decode-stage source registers
//   rs1E, rs2E, rdE         execute-stage source/destination registers
//   rdM, rdW                memory / writeback destination registers
//   RegWriteM, RegWriteW    memory / writeback write enables
//   ResultSrcE0             execute instruction is a load
//   PCSrcE                  taken branch/jump resolved in execute
//   MulDivStartE            execute instruction is a multi-cycle op
//   MulDivDoneE             multi-cycle unit result valid
//   StallF, StallD          hold PC and fetch/decode register
//   StallE                  hold execute-stage operands
//   FlushD                  clear fetch/decode register
//   FlushE                  clear decode/execute register
//   FlushM                  bubble into execute/memory register
//   ForwardAE, ForwardBE    00 register file, 01 W result, 10 M result
//   MulDivBusy              multi-cycle FSM is in BUSY
//   Timeout                 sticky watchdog flag
//   StallCount              saturating count of cycles with StallF=1
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MAX_BUSY = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MulDivStartE,
    input  logic             MulDivDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivBusy,
    output logic             Timeout,
    output logic [CNT_W-1:0] StallCount
);

    // Busy counter must be able to hold MAX_BUSY itself.
    localparam int BW = $clog2(MAX_BUSY + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BUSY);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lw_stall;
    logic start;
    logic watchdog;

    // Forwarding select for one execute source register; M is the younger
    // producer so it takes priority over W. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(rs1E, RegWriteM, rdM, RegWriteW, rdW);
    assign ForwardBE = fwd_sel(rs2E, RegWriteM, rdM, RegWriteW, rdW);

    // Load in execute whose destination is read by the decode instruction.
    assign lw_stall = ResultSrcE0 && (rdE != 5'd0) &&
                      ((rdE == rs1D) || (rdE == rs2D));

    // A taken branch squashes the multi-cycle op, so it never starts.
    assign start    = (state_q == IDLE) && MulDivStartE && !PCSrcE;
    // Done on the last allowed cycle still wins over the abort.
    assign watchdog = (state_q == BUSY) && !MulDivDoneE && (busy_cnt_q == MAX_CNT);

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Freeze the front end and hold the op in execute while
                    // the unit runs; bubbles go into memory instead.
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    FlushM     = 1'b1;
                    busy_cnt_d = BW'(1);
                    state_d    = BUSY;
                end else begin
                    // Branch flush overrides the load-use stall: the
                    // stalled instruction is on the wrong path anyway.
                    StallF = lw_stall && !PCSrcE;
                    StallD = lw_stall && !PCSrcE;
                    FlushD = PCSrcE;
                    FlushE = PCSrcE || lw_stall;
                end
            end
            BUSY: begin
                // PCSrcE is ignored here: the execute slot holds the
                // multi-cycle op, not a branch.
                if (MulDivDoneE) begin
                    state_d    = IDLE;
                    busy_cnt_d = '0;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    if (watchdog) begin
                        timeout_d  = 1'b1;
                        state_d    = IDLE;
                        busy_cnt_d = '0;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                busy_cnt_d = '0;
            end
        endcase
    end

    // Saturating performance counter of front-end stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MulDivBusy = (state_q == BUSY);
    assign Timeout    = timeout_q;
    assign StallCount = stall_cnt_q;

endmodule
